// File: rtl/ntt_batch_sequencer.sv
// Read/write address sequencer feeding a batch of polynomials through an NTT core.
// Reads stream {poly, pair} back to back; writes follow core_valid, optionally bit-reversed.
module ntt_batch_sequencer #(
    parameter int unsigned LOGN        = 12,
    parameter int unsigned LOGP        = 2,
    parameter int unsigned START_DELAY = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     intt,
    input  logic [LOGP:0]            num_poly,
    input  logic                     bitrev_en,
    input  logic                     core_valid,
    output logic [LOGP+LOGN-2:0]     read_address,
    output logic                     read_en,
    output logic                     core_start,
    output logic                     core_intt,
    output logic [LOGP+LOGN-2:0]     write_address,
    output logic                     wea,
    output logic                     busy,
    output logic                     finish
);

    localparam int unsigned PW   = LOGN - 1;
    localparam int unsigned AW   = LOGP + LOGN - 1;
    localparam int unsigned NW   = LOGP + 1;
    localparam int unsigned MAXP = 1 << LOGP;
    localparam int unsigned DW   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    typedef enum logic [2:0] {IDLE, DELAY, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     np_q, np_d, np_in, np_last;
    logic              bitrev_q, bitrev_d, intt_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic [PW-1:0]     rd_pair_q, rd_pair_d, wr_pair_q, wr_pair_d;
    logic [LOGP-1:0]   rd_poly_q, rd_poly_d, wr_poly_q, wr_poly_d;
    logic              rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic              rd_last, wr_last;
    logic              read_en_d, core_start_d, wea_d, busy_d, finish_d;
    logic [AW-1:0]     read_address_d, write_address_d;

    function automatic logic [PW-1:0] bit_reverse(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(PW); i++) r[i] = v[int'(PW) - 1 - i];
        return r;
    endfunction

    assign np_in   = (num_poly > NW'(MAXP)) ? NW'(MAXP) : num_poly;
    assign np_last = np_q - NW'(1);
    assign rd_last = (rd_pair_q == '1) && ({1'b0, rd_poly_q} == np_last);
    assign wr_last = (wr_pair_q == '1) && ({1'b0, wr_poly_q} == np_last);

    // Next state, counters and next registered outputs
    always_comb begin
        state_d         = state_q;
        np_d            = np_q;
        bitrev_d        = bitrev_q;
        intt_d          = core_intt;
        dly_d           = dly_q;
        rd_pair_d       = rd_pair_q;
        rd_poly_d       = rd_poly_q;
        rd_done_d       = rd_done_q;
        wr_pair_d       = wr_pair_q;
        wr_poly_d       = wr_poly_q;
        wr_done_d       = wr_done_q;
        read_en_d       = 1'b0;
        core_start_d    = 1'b0;
        read_address_d  = read_address;
        wea_d           = 1'b0;
        write_address_d = write_address;

        case (state_q)
            IDLE: begin
                if (start) begin
                    np_d      = np_in;
                    bitrev_d  = bitrev_en;
                    intt_d    = intt;
                    dly_d     = '0;
                    rd_pair_d = '0;
                    rd_poly_d = '0;
                    rd_done_d = 1'b0;
                    wr_pair_d = '0;
                    wr_poly_d = '0;
                    wr_done_d = 1'b0;
                    state_d   = (np_in == '0) ? DONE : ((START_DELAY == 0) ? RUN : DELAY);
                end
            end
            DELAY: begin
                dly_d = dly_q + DW'(1);
                if (dly_q == DW'(START_DELAY - 1)) state_d = RUN;
            end
            RUN, DRAIN: begin
                if (state_q == RUN && !rd_done_q) begin
                    read_en_d      = 1'b1;
                    core_start_d   = (rd_pair_q == '0);
                    read_address_d = {rd_poly_q, rd_pair_q};
                    if (rd_last) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_pair_d = rd_pair_q + PW'(1);
                        if (rd_pair_q == '1) rd_poly_d = rd_poly_q + LOGP'(1);
                    end
                end
                // Writes stop counting after the last pair so no address overruns the batch
                if (core_valid && !wr_done_q) begin
                    wea_d           = 1'b1;
                    write_address_d = {wr_poly_q, bitrev_q ? bit_reverse(wr_pair_q) : wr_pair_q};
                    if (wr_last) begin
                        wr_done_d = 1'b1;
                    end else begin
                        wr_pair_d = wr_pair_q + PW'(1);
                        if (wr_pair_q == '1) wr_poly_d = wr_poly_q + LOGP'(1);
                    end
                end
                if (state_q == RUN && rd_done_q) state_d = wr_done_q ? DONE : DRAIN;
                if (state_q == DRAIN && wr_done_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        finish_d = (state_d == DONE);
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            np_q          <= '0;
            bitrev_q      <= 1'b0;
            core_intt     <= 1'b0;
            dly_q         <= '0;
            rd_pair_q     <= '0;
            rd_poly_q     <= '0;
            rd_done_q     <= 1'b0;
            wr_pair_q     <= '0;
            wr_poly_q     <= '0;
            wr_done_q     <= 1'b0;
            read_en       <= 1'b0;
            core_start    <= 1'b0;
            read_address  <= '0;
            wea           <= 1'b0;
            write_address <= '0;
            busy          <= 1'b0;
            finish        <= 1'b0;
        end else begin
            state_q       <= state_d;
            np_q          <= np_d;
            bitrev_q      <= bitrev_d;
            core_intt     <= intt_d;
            dly_q         <= dly_d;
            rd_pair_q     <= rd_pair_d;
            rd_poly_q     <= rd_poly_d;
            rd_done_q     <= rd_done_d;
            wr_pair_q     <= wr_pair_d;
            wr_poly_q     <= wr_poly_d;
            wr_done_q     <= wr_done_d;
            read_en       <= read_en_d;
            core_start    <= core_start_d;
            read_address  <= read_address_d;
            wea           <= wea_d;
            write_address <= write_address_d;
            busy          <= busy_d;
            finish        <= finish_d;
        end
    end

endmodule

// File: tb/tb_ntt_batch_sequencer.sv
// Directed bench for ntt_batch_sequencer with LOGN=4 (8 pairs per polynomial), LOGP=2, START_DELAY=10.
module tb_ntt_batch_sequencer;

    localparam int unsigned LOGN = 4;
    localparam int unsigned LOGP = 2;
    localparam int unsigned SD   = 10;

    logic       clk = 1'b0;
    logic       rst, start, intt, bitrev_en, core_valid;
    logic [2:0] num_poly;
    logic [4:0] read_address, write_address;
    logic       read_en, core_start, core_intt, wea, busy, finish;

    int vectors = 0;
    int errors  = 0;
    int rd_a[$], rd_c[$], cs_a[$], wr_a[$], wr_c[$], fin_c[$];
    int busy_n, intt_seen;
    int rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    ntt_batch_sequencer #(.LOGN(LOGN), .LOGP(LOGP), .START_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .intt(intt), .num_poly(num_poly),
        .bitrev_en(bitrev_en), .core_valid(core_valid), .read_address(read_address),
        .read_en(read_en), .core_start(core_start), .core_intt(core_intt),
        .write_address(write_address), .wea(wea), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // core_valid pattern, driven after sampling cycle k (seen by the DUT at edge k+1)
    function automatic logic cv_fn(input int mode, input int k);
        case (mode)
            0:       return (k >= 11) && (k < 31);
            1:       return (k >= 12);
            2:       return ((k <= 9) && (k % 2 == 1)) || (k >= 12);
            3:       return (k >= 20) && ((k - 20) % 2 == 0);
            default: return 1'b1;
        endcase
    endfunction

    // Cycle 0 is the sample right after the start edge
    task automatic run_batch(input int np, input logic iv, input logic br, input int mode, input int restart_at);
        int k;
        bit stop;
        rd_a.delete(); rd_c.delete(); cs_a.delete();
        wr_a.delete(); wr_c.delete(); fin_c.delete();
        busy_n = 0; intt_seen = -1;
        start = 1'b1; intt = iv; num_poly = 3'(np); bitrev_en = br; core_valid = 1'b0;
        step();
        start = 1'b0; k = 0; stop = 1'b0;
        while (!stop) begin
            if (read_en) begin rd_a.push_back(int'(read_address)); rd_c.push_back(k); end
            if (core_start) cs_a.push_back(int'(read_address));
            if (wea) begin wr_a.push_back(int'(write_address)); wr_c.push_back(k); end
            if (finish) fin_c.push_back(k);
            if (k == 1) intt_seen = int'(core_intt);
            if (busy) busy_n++; else stop = 1'b1;
            if (k >= 400) stop = 1'b1;
            core_valid = cv_fn(mode, k);
            start = (k == restart_at);
            if (!stop) begin step(); k++; end
        end
        core_valid = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; intt = 1'b0; num_poly = 3'd0; bitrev_en = 1'b0; core_valid = 1'b0;
        step(); step();
        vectors++; if ({read_en, wea, core_start, busy, finish, core_intt} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {read_en, wea, core_start, busy, finish, core_intt}); end
        vectors++; if (read_address !== 5'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", read_address); end
        vectors++; if (write_address !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", write_address); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        run_batch(1, 1'b0, 1'b0, 0, -1);
        vectors++; if (rd_a.size() !== 8) begin errors++; $display("FAIL single_rd_count got %0d want 8", rd_a.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (rd_a[i] !== i || rd_c[i] !== 11 + i) begin errors++; $display("FAIL single_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, rd_a[i], rd_c[i], i, 11 + i); end
        end
        vectors++; if (wr_a.size() !== 8) begin errors++; $display("FAIL single_wr_count got %0d want 8", wr_a.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (wr_a[i] !== i || wr_c[i] !== 12 + i) begin errors++; $display("FAIL single_wr[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, wr_a[i], wr_c[i], i, 12 + i); end
        end
        vectors++; if (fin_c.size() !== 1 || fin_c[0] !== 20) begin errors++; $display("FAIL single_finish got count %0d cyc %0d want 1 at 20", fin_c.size(), fin_c[0]); end
        vectors++; if (cs_a.size() !== 1 || cs_a[0] !== 0) begin errors++; $display("FAIL single_core_start got count %0d want 1", cs_a.size()); end
        vectors++; if (busy_n !== 21) begin errors++; $display("FAIL single_busy got %0d want 21", busy_n); end
        vectors++; if (intt_seen !== 0) begin errors++; $display("FAIL single_intt got %0d want 0", intt_seen); end
    endtask

    task automatic test_bitrev();
        run_batch(3, 1'b1, 1'b1, 1, -1);
        vectors++; if (rd_a.size() !== 24) begin errors++; $display("FAIL bitrev_rd_count got %0d want 24", rd_a.size()); end
        for (int i = 0; i < 24; i++) begin
            vectors++; if (rd_a[i] !== i || rd_c[i] !== 11 + i) begin errors++; $display("FAIL bitrev_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, rd_a[i], rd_c[i], i, 11 + i); end
        end
        vectors++; if (cs_a.size() !== 3 || cs_a[0] !== 0 || cs_a[1] !== 8 || cs_a[2] !== 16) begin errors++; $display("FAIL bitrev_core_start got count %0d first %0d want 0,8,16", cs_a.size(), cs_a[0]); end
        vectors++; if (wr_a.size() !== 24) begin errors++; $display("FAIL bitrev_wr_count got %0d want 24", wr_a.size()); end
        for (int i = 0; i < 24; i++) begin
            vectors++; if (wr_a[i] !== (i / 8) * 8 + rev[i % 8] || wr_c[i] !== 13 + i) begin errors++; $display("FAIL bitrev_wr[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, wr_a[i], wr_c[i], (i / 8) * 8 + rev[i % 8], 13 + i); end
        end
        vectors++; if (fin_c.size() !== 1 || fin_c[0] !== 37) begin errors++; $display("FAIL bitrev_finish got count %0d cyc %0d want 1 at 37", fin_c.size(), fin_c[0]); end
        vectors++; if (intt_seen !== 1) begin errors++; $display("FAIL bitrev_intt got %0d want 1", intt_seen); end
        vectors++; if (core_intt !== 1'b1) begin errors++; $display("FAIL bitrev_intt_hold got %0d want 1", core_intt); end
    endtask

    task automatic test_zero();
        run_batch(0, 1'b0, 1'b0, 4, -1);
        vectors++; if (busy_n !== 1) begin errors++; $display("FAIL zero_busy got %0d want 1", busy_n); end
        vectors++; if (fin_c.size() !== 1 || fin_c[0] !== 0) begin errors++; $display("FAIL zero_finish got count %0d cyc %0d want 1 at 0", fin_c.size(), fin_c[0]); end
        vectors++; if (rd_a.size() !== 0 || wr_a.size() !== 0) begin errors++; $display("FAIL zero_access got rd %0d wr %0d want 0 0", rd_a.size(), wr_a.size()); end
    endtask

    task automatic test_restart();
        run_batch(1, 1'b0, 1'b0, 2, 15);
        vectors++; if (rd_a.size() !== 8 || rd_c[0] !== 11 || rd_c[7] !== 18) begin errors++; $display("FAIL restart_reads got count %0d first %0d want 8 from 11", rd_a.size(), rd_c[0]); end
        vectors++; if (wr_a.size() !== 8 || wr_c[0] !== 13) begin errors++; $display("FAIL restart_writes got count %0d first cyc %0d want 8 from 13", wr_a.size(), wr_c[0]); end
        vectors++; if (wr_a[7] !== 7) begin errors++; $display("FAIL restart_last_waddr got %0d want 7", wr_a[7]); end
        vectors++; if (fin_c.size() !== 1 || fin_c[0] !== 21) begin errors++; $display("FAIL restart_finish got count %0d cyc %0d want 1 at 21", fin_c.size(), fin_c[0]); end
        vectors++; if (busy_n !== 22) begin errors++; $display("FAIL restart_busy got %0d want 22", busy_n); end
    endtask

    task automatic test_midbatch_reset();
        start = 1'b1; intt = 1'b1; num_poly = 3'd2; bitrev_en = 1'b0; core_valid = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            core_valid = (k >= 11);
            step();
        end
        vectors++; if (read_en !== 1'b1 || read_address !== 5'd4) begin errors++; $display("FAIL midrst_5th_read got en %0d addr %0d want 1 4", read_en, read_address); end
        rst = 1'b1;
        step();
        vectors++; if ({read_en, wea, core_start, busy, finish, core_intt} !== 6'b0) begin errors++; $display("FAIL midrst_flags got %b want 000000", {read_en, wea, core_start, busy, finish, core_intt}); end
        vectors++; if (read_address !== 5'd0 || write_address !== 5'd0) begin errors++; $display("FAIL midrst_addr got r %0d w %0d want 0 0", read_address, write_address); end
        rst = 1'b0; core_valid = 1'b0;
        step();
        run_batch(1, 1'b0, 1'b0, 0, -1);
        vectors++; if (rd_a.size() !== 8 || rd_a[0] !== 0 || rd_c[0] !== 11) begin errors++; $display("FAIL midrst_rerun_rd got count %0d addr %0d cyc %0d want 8 0 11", rd_a.size(), rd_a[0], rd_c[0]); end
        vectors++; if (wr_a.size() !== 8 || wr_a[0] !== 0) begin errors++; $display("FAIL midrst_rerun_wr got count %0d addr %0d want 8 0", wr_a.size(), wr_a[0]); end
        vectors++; if (fin_c.size() !== 1) begin errors++; $display("FAIL midrst_rerun_finish got %0d want 1", fin_c.size()); end
    endtask

    task automatic test_gapped_drain();
        run_batch(1, 1'b0, 1'b0, 3, -1);
        vectors++; if (wr_a.size() !== 8) begin errors++; $display("FAIL gap_wr_count got %0d want 8", wr_a.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (wr_a[i] !== i || wr_c[i] !== 21 + 2 * i) begin errors++; $display("FAIL gap_wr[%0d] got addr %0d cyc %0d want addr %0d cyc %0d", i, wr_a[i], wr_c[i], i, 21 + 2 * i); end
        end
        vectors++; if (fin_c.size() !== 1 || fin_c[0] !== 36) begin errors++; $display("FAIL gap_finish got count %0d cyc %0d want 1 at 36", fin_c.size(), fin_c[0]); end
    endtask

    task automatic test_clamp();
        run_batch(7, 1'b0, 1'b0, 1, -1);
        vectors++; if (rd_a.size() !== 32 || rd_a[31] !== 31) begin errors++; $display("FAIL clamp_reads got count %0d last %0d want 32 31", rd_a.size(), rd_a[31]); end
        vectors++; if (wr_a.size() !== 32 || wr_a[31] !== 31) begin errors++; $display("FAIL clamp_writes got count %0d last %0d want 32 31", wr_a.size(), wr_a[31]); end
        vectors++; if (fin_c.size() !== 1) begin errors++; $display("FAIL clamp_finish got %0d want 1", fin_c.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bitrev();
        test_zero();
        test_restart();
        test_midbatch_reset();
        test_gapped_drain();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
